// File: rtl/spi_pkg.sv
// Shared constants and state encoding for the SPI nibble receiver.
package spi_pkg;

  localparam int unsigned DATA_W_DEF      = 8;
  localparam int unsigned SYNC_STAGES_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_e;

  // Idle line levels, used to preset the synchronisers so reset creates no false edges
  localparam logic SCLK_IDLE = 1'b0;
  localparam logic CS_N_IDLE = 1'b1;
  localparam logic MOSI_IDLE = 1'b0;

endpackage

// File: rtl/spi_nibble_rx_if.sv
// SPI pin bundle between the master and the nibble receiver.
interface spi_nibble_rx_if;
  logic sclk;
  logic cs_n;
  logic mosi;
  logic miso;

  modport master (output sclk, output cs_n, output mosi, input miso);
  modport slave  (input sclk, input cs_n, input mosi, output miso);
endinterface

// File: rtl/sync_ff.sv
// Single-bit multi-flop synchroniser with a configurable reset level.
module sync_ff #(
  parameter int unsigned DEPTH   = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [DEPTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {DEPTH{RST_VAL}};
    end else begin
      sync_q <= {sync_q[DEPTH-2:0], d_i};
    end
  end

  assign q_o = sync_q[DEPTH-1];

endmodule

// File: rtl/spi_nibble_rx.sv
// SPI mode-0 slave receiver: oversampled byte assembly, previous-byte echo on MISO,
// and a stable low nibble for the downstream 7-segment decoder.
module spi_nibble_rx
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  spi_nibble_rx_if.slave    spi,
  output logic [DATA_W-1:0] data_o,
  output logic              data_valid_o,
  output logic [3:0]        nibble_o,
  output logic              frame_err_o
);

  localparam int unsigned CNT_W  = $clog2(DATA_W + 1);
  localparam int unsigned WARM_W = $clog2(SYNC_STAGES + 2);

  localparam logic [1:0] S_IDLE  = 2'(ST_IDLE);
  localparam logic [1:0] S_LOAD  = 2'(ST_LOAD);
  localparam logic [1:0] S_SHIFT = 2'(ST_SHIFT);

  logic sclk_s, cs_n_s, mosi_s;

  sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(SCLK_IDLE)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d_i(spi.sclk), .q_o(sclk_s));
  sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(CS_N_IDLE)) u_sync_cs_n (
    .clk(clk), .rst_n(rst_n), .d_i(spi.cs_n), .q_o(cs_n_s));
  sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(MOSI_IDLE)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .d_i(spi.mosi), .q_o(mosi_s));

  logic              sclk_hist_q, cs_hist_q;
  logic [WARM_W-1:0] warm_q;
  logic              arm_q;
  logic              warm_done;

  // Frame starts are only accepted after cs_n has been seen high post-reset
  assign warm_done = (warm_q == WARM_W'(SYNC_STAGES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_hist_q <= SCLK_IDLE;
      cs_hist_q   <= CS_N_IDLE;
      warm_q      <= '0;
      arm_q       <= 1'b0;
    end else begin
      sclk_hist_q <= sclk_s;
      cs_hist_q   <= cs_n_s;
      if (!warm_done) warm_q <= warm_q + WARM_W'(1);
      arm_q       <= arm_q | (warm_done & cs_n_s);
    end
  end

  logic sclk_rise, sclk_fall, cs_fall, cs_rise;
  assign sclk_rise = sclk_s & ~sclk_hist_q;
  assign sclk_fall = ~sclk_s & sclk_hist_q;
  assign cs_fall   = ~cs_n_s & cs_hist_q;
  assign cs_rise   = cs_n_s & ~cs_hist_q;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              miso_q, miso_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      tx_q    <= '0;
      data_q  <= '0;
      miso_q  <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      data_q  <= data_d;
      miso_q  <= miso_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    data_d  = data_q;
    miso_d  = miso_q;
    valid_d = 1'b0;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        cnt_d  = '0;
        miso_d = 1'b0;
        if (cs_fall && arm_q) state_d = S_LOAD;
      end
      S_LOAD: begin
        tx_d    = data_q;
        miso_d  = data_q[DATA_W-1];
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (cnt_q == CNT_W'(DATA_W)) begin
          data_d  = shift_q;
          valid_d = 1'b1;
          err_d   = 1'b0;
          cnt_d   = '0;
          if (cs_rise) begin
            state_d = S_IDLE;
            miso_d  = 1'b0;
          end
        end else if (cs_rise) begin
          // cs_n wins over a coincident sclk edge; partial bits are dropped
          state_d = S_IDLE;
          miso_d  = 1'b0;
          cnt_d   = '0;
          if (cnt_q != '0) err_d = 1'b1;
        end else if (sclk_rise) begin
          shift_d = {shift_q[DATA_W-2:0], mosi_s};
          cnt_d   = cnt_q + CNT_W'(1);
        end else if (sclk_fall) begin
          // A fall with an empty counter closes a byte: reload the echo for the next one
          if (cnt_q == '0) begin
            tx_d   = data_q;
            miso_d = data_q[DATA_W-1];
          end else begin
            tx_d   = {tx_q[DATA_W-2:0], 1'b0};
            miso_d = tx_q[DATA_W-2];
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        miso_d  = 1'b0;
      end
    endcase
  end

  assign spi.miso     = miso_q;
  assign data_o       = data_q;
  assign nibble_o     = data_q[3:0];
  assign data_valid_o = valid_q;
  assign frame_err_o  = err_q;

endmodule
